// File: rtl/cfd_pkg.sv
// Shared definitions for the cable fault detection datapath.
// Holds the default sample/buffer geometry and the echo_locator FSM state
// encoding so the MCU-interface block can decode the same states.
package cfd_pkg;

    localparam int DATA_W = 8;    // ADC sample width
    localparam int ADDR_W = 9;    // capture buffer address width
    localparam int DEPTH  = 512;  // capture buffer depth (2**ADDR_W)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } cfd_state_e;

endpackage

// File: rtl/echo_ram.sv
// Simple dual-port DEPTH x DATA_W sample buffer.
// Synchronous write port, registered single-cycle read port; written in the
// plain form block-RAM inference expects, so contents are not reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates the cycle after
//   rd_addr  - read address
//   rd_data  - registered read data
module echo_ram #(
    parameter int DATA_W = cfd_pkg::DATA_W,
    parameter int ADDR_W = cfd_pkg::ADDR_W,
    parameter int DEPTH  = cfd_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/echo_locator.sv
// Post-capture echo analysis.
// Mirrors the capture stage's RAM write stream into a private buffer, then on
// start scans indices BLANK..DEPTH-1 for the first sample whose deviation from
// the baseline (sample 0) reaches the threshold, and for the peak deviation.
// Ports:
//   clk_30M  - system/sample clock
//   sys_rst  - asynchronous reset, active-high
//   wr_en/wr_addr/wr_data - capture stage write stream
//   thresh   - echo threshold, latched on an accepted start
//   start    - single-cycle scan request (ignored unless idle)
//   busy     - scan in progress
//   done     - one-cycle pulse when results are valid
//   found/echo_idx       - first threshold crossing
//   peak_idx/peak_val    - location and size of the maximum deviation
//   overrun  - sticky: a write was dropped because a scan was running
module echo_locator #(
    parameter int DATA_W = cfd_pkg::DATA_W,
    parameter int ADDR_W = cfd_pkg::ADDR_W,
    parameter int DEPTH  = cfd_pkg::DEPTH,
    parameter int BLANK  = 8
) (
    input  logic              clk_30M,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] thresh,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] echo_idx,
    output logic [ADDR_W-1:0] peak_idx,
    output logic [DATA_W-1:0] peak_val,
    output logic              overrun
);

    import cfd_pkg::*;

    localparam logic [ADDR_W-1:0] BLANK_A = ADDR_W'(BLANK);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    cfd_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [DATA_W-1:0] baseline_q, baseline_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] echo_idx_q, echo_idx_d;
    logic [ADDR_W-1:0] peak_idx_q, peak_idx_d;
    logic [DATA_W-1:0] peak_val_q, peak_val_d;
    logic              overrun_q, overrun_d;

    logic              busy_w;
    logic              ram_we;
    logic [DATA_W-1:0] rd_data;
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0] dev;

    // DONE is deliberately outside busy so busy drops in the done cycle.
    assign busy_w = (state_q == SCAN) || (state_q == FLUSH);
    assign ram_we = wr_en && !busy_w;

    echo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk_30M),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state_q == SCAN),
        .rd_addr (rp_q),
        .rd_data (rd_data)
    );

    // |sample - baseline| in DATA_W+1 signed bits; magnitude always fits DATA_W.
    assign diff = $signed({1'b0, rd_data}) - $signed({1'b0, baseline_q});
    assign dev  = diff[DATA_W] ? DATA_W'(-diff) : diff[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        rp_d       = rp_q;
        rd_vld_d   = 1'b0;
        rd_idx_d   = rd_idx_q;
        baseline_d = baseline_q;
        thresh_d   = thresh_q;
        found_d    = found_q;
        echo_idx_d = echo_idx_q;
        peak_idx_d = peak_idx_q;
        peak_val_d = peak_val_q;
        overrun_d  = overrun_q;

        if (ram_we && (wr_addr == '0)) baseline_d = wr_data;
        if (wr_en && busy_w)           overrun_d  = 1'b1;

        // Evaluate the sample returned by last cycle's read.
        if (rd_vld_q) begin
            if (!found_q && (dev >= thresh_q)) begin
                found_d    = 1'b1;
                echo_idx_d = rd_idx_q;
            end
            if (dev > peak_val_q) begin
                peak_val_d = dev;
                peak_idx_d = rd_idx_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    thresh_d   = thresh;
                    found_d    = 1'b0;
                    overrun_d  = 1'b0;
                    echo_idx_d = '0;
                    peak_val_d = '0;
                    peak_idx_d = BLANK_A;
                    rp_d       = BLANK_A;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                rd_vld_d = 1'b1;
                rd_idx_d = rp_q;
                rp_d     = rp_q + 1'b1;
                if (rp_q == LAST_A) state_d = FLUSH;
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_30M or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            rp_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            baseline_q <= '0;
            thresh_q   <= '0;
            found_q    <= 1'b0;
            echo_idx_q <= '0;
            peak_idx_q <= '0;
            peak_val_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rp_q       <= rp_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            baseline_q <= baseline_d;
            thresh_q   <= thresh_d;
            found_q    <= found_d;
            echo_idx_q <= echo_idx_d;
            peak_idx_q <= peak_idx_d;
            peak_val_q <= peak_val_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy     = busy_w;
    assign done     = (state_q == DONE);
    assign found    = found_q;
    assign echo_idx = echo_idx_q;
    assign peak_idx = peak_idx_q;
    assign peak_val = peak_val_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_echo_locator.sv
module tb_echo_locator;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int DEP = 512;
    localparam int BLK = 8;

    logic          clk_30M = 1'b0;
    logic          sys_rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] thresh;
    logic          start;
    logic          busy, done, found, overrun;
    logic [AW-1:0] echo_idx, peak_idx;
    logic [DW-1:0] peak_val;

    echo_locator #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BLANK(BLK)) dut (
        .clk_30M (clk_30M), .sys_rst (sys_rst),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .thresh (thresh), .start (start),
        .busy (busy), .done (done), .found (found),
        .echo_idx (echo_idx), .peak_idx (peak_idx), .peak_val (peak_val),
        .overrun (overrun)
    );

    always #5 clk_30M = ~clk_30M;

    int cyc = 0;
    always @(posedge clk_30M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural model: buffer contents, baseline, scan-in-progress flag.
    int mem [DEP];
    int base = 0;
    bit m_busy = 0;
    int t0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Expected results straight from the rules: first crossing, then the
    // maximum deviation and the first index that attains it.
    task automatic mdl(input int thr, output int f, output int e, output int pi, output int pv);
        f = 0; e = 0; pv = 0; pi = BLK;
        for (int i = BLK; i < DEP; i++)
            if (iabs(mem[i] - base) >= thr) begin f = 1; e = i; break; end
        for (int i = BLK; i < DEP; i++)
            if (iabs(mem[i] - base) > pv) pv = iabs(mem[i] - base);
        for (int i = BLK; i < DEP; i++)
            if (iabs(mem[i] - base) == pv) begin pi = i; break; end
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d[DW-1:0];
        @(posedge clk_30M); #1;
        wr_en = 1'b0;
        if (!m_busy) begin
            mem[a] = d;
            if (a == 0) base = d;
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < DEP; i++) wr(i, v);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < DEP; i++) wr(i, int'($urandom_range(0, 255)));
    endtask

    // wa >= 0 drives a write in the same cycle as start.
    task automatic start_scan(input int thr, input int wa = -1, input int wd = 0);
        thresh = thr[DW-1:0];
        start = 1'b1;
        if (wa >= 0) begin wr_en = 1'b1; wr_addr = wa[AW-1:0]; wr_data = wd[DW-1:0]; end
        @(posedge clk_30M); #1;
        start = 1'b0; wr_en = 1'b0;
        if (wa >= 0) begin mem[wa] = wd; if (wa == 0) base = wd; end
        m_busy = 1;
        t0 = cyc;
        chk("busy_rise", {31'd0, busy}, 1);
        chk("overrun_clr", {31'd0, overrun}, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 600) begin
            @(posedge clk_30M); #1; n++;
        end
        m_busy = 0;
        chk("done_seen", {31'd0, done}, 1);
        chk("latency", cyc - t0 + 1, 506);
        chk("busy_fall", {31'd0, busy}, 0);
    endtask

    task automatic results(input string tag, input int f, input int e, input int pi, input int pv);
        chk({tag, "_found"}, {31'd0, found}, f);
        chk({tag, "_echo"}, {23'd0, echo_idx}, e);
        chk({tag, "_pidx"}, {23'd0, peak_idx}, pi);
        chk({tag, "_pval"}, {24'd0, peak_val}, pv);
        @(posedge clk_30M); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_hold"}, {23'd0, echo_idx}, e);
    endtask

    initial begin
        int f, e, pi, pv, thr, dcnt;
        sys_rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; thresh = '0; start = 0;
        repeat (3) @(posedge clk_30M); #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_found", {31'd0, found}, 0);
        chk("rst_echo", {23'd0, echo_idx}, 0);
        chk("rst_pidx", {23'd0, peak_idx}, 0);
        chk("rst_pval", {24'd0, peak_val}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        sys_rst = 1'b0;
        @(posedge clk_30M); #1;

        // Flat buffer: no echo, peak stays at its start values.
        fill(128);
        start_scan(20); wait_done(); results("flat", 0, 0, 8, 0);

        // Two spikes: first crossing vs larger peak.
        fill(128); wr(200, 170); wr(300, 200);
        start_scan(30); wait_done(); results("spikes", 1, 200, 300, 72);

        // Large sample inside the blanking window is ignored.
        fill(128); wr(5, 255); wr(50, 60);
        start_scan(40); wait_done(); results("blank", 1, 50, 50, 68);

        // Equal peaks keep the earliest index; threshold never reached.
        fill(128); wr(100, 90); wr(400, 90);
        start_scan(100); wait_done(); results("ties", 0, 0, 100, 38);

        // Write during a scan is dropped and flags overrun.
        fill(128);
        start_scan(30);
        repeat (20) @(posedge clk_30M); #1;
        wr(10, 255);
        chk("overrun_set", {31'd0, overrun}, 1);
        wait_done(); results("ovr1", 0, 0, 8, 0);
        chk("overrun_sticky", {31'd0, overrun}, 1);
        start_scan(30); wait_done(); results("ovr2", 0, 0, 8, 0);

        // Write in the same cycle as start is visible to the scan.
        start_scan(50, 8, 250); wait_done(); results("same_cyc", 1, 8, 8, 122);

        // Zero threshold hits the first scanned sample.
        start_scan(0); wait_done(); results("thr0", 1, 8, 8, 122);

        // Randomized buffers against the model.
        for (int k = 0; k < 4; k++) begin
            fill_rand();
            thr = int'($urandom_range(0, 140));
            mdl(thr, f, e, pi, pv);
            start_scan(thr); wait_done(); results($sformatf("rnd%0d", k), f, e, pi, pv);
        end

        // Reset mid-scan.
        fill(128); wr(200, 170); wr(300, 200);
        start_scan(30);
        repeat (320) @(posedge clk_30M); #1;
        wr(10, 255);
        chk("pre_rst_found", {31'd0, found}, 1);
        chk("pre_rst_overrun", {31'd0, overrun}, 1);
        sys_rst = 1'b1; #1;
        m_busy = 0; base = 0;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_found", {31'd0, found}, 0);
        chk("mid_rst_echo", {23'd0, echo_idx}, 0);
        chk("mid_rst_pidx", {23'd0, peak_idx}, 0);
        chk("mid_rst_pval", {24'd0, peak_val}, 0);
        chk("mid_rst_overrun", {31'd0, overrun}, 0);
        @(posedge clk_30M); #1;
        sys_rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk_30M); #1;
            if (done === 1'b1) dcnt++;
        end
        chk("no_done_after_rst", dcnt, 0);
        chk("idle_after_rst", {31'd0, busy}, 0);

        // Buffer survives reset; baseline is back to 0.
        mdl(250, f, e, pi, pv);
        start_scan(250); wait_done(); results("post_rst", f, e, pi, pv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
